// File: rtl/cpu_read_mux.sv
// rtl/cpu_read_mux.sv - CPU read steering between boot overlay and block RAM
module cpu_read_mux #(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_rd,
  output logic [7:0]            cpu_din,
  output logic                  cpu_ready,
  output logic                  boot_rd,
  input  logic [7:0]            boot_data,
  input  logic                  boot_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_data,
  output logic                  boot_done
);

  typedef enum logic [2:0] {
    IDLE, BOOT_REQ, BOOT_CHK, MEM_REQ, MEM_WAIT, ACK
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t                state, state_n;
  logic                  armed, armed_n;
  logic [3:0]            wait_cnt, wait_cnt_n;
  logic [7:0]            din_n;
  logic                  ready_n, boot_rd_n, mem_rd_n, boot_done_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      armed     <= 1'b1;
      wait_cnt  <= 4'd0;
      cpu_din   <= 8'd0;
      cpu_ready <= 1'b0;
      boot_rd   <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      boot_done <= 1'b0;
    end else begin
      state     <= state_n;
      armed     <= armed_n;
      wait_cnt  <= wait_cnt_n;
      cpu_din   <= din_n;
      cpu_ready <= ready_n;
      boot_rd   <= boot_rd_n;
      mem_rd    <= mem_rd_n;
      mem_addr  <= mem_addr_n;
      boot_done <= boot_done_n;
    end
  end

  // Next values of every output register; strobes default low so each is a single-cycle pulse.
  always_comb begin
    state_n     = state;
    armed_n     = cpu_rd ? armed : 1'b1;
    wait_cnt_n  = wait_cnt;
    din_n       = cpu_din;
    ready_n     = 1'b0;
    boot_rd_n   = 1'b0;
    mem_rd_n    = 1'b0;
    mem_addr_n  = mem_addr;
    boot_done_n = boot_done;
    case (state)
      IDLE: begin
        if (cpu_rd && armed) begin
          armed_n    = 1'b0;
          mem_addr_n = cpu_addr;
          if (!boot_done && boot_valid) begin
            state_n   = BOOT_REQ;
            boot_rd_n = 1'b1;
          end else begin
            state_n  = MEM_REQ;
            mem_rd_n = 1'b1;
          end
        end
      end
      BOOT_REQ: state_n = BOOT_CHK;
      BOOT_CHK: begin
        if (boot_valid) begin
          din_n   = boot_data;
          ready_n = 1'b1;
          state_n = ACK;
        end else begin
          // Overlay ran dry on this strobe: fetch the same address from RAM instead.
          boot_done_n = 1'b1;
          mem_rd_n    = 1'b1;
          state_n     = MEM_REQ;
        end
      end
      MEM_REQ: begin
        wait_cnt_n = LAT;
        state_n    = MEM_WAIT;
      end
      MEM_WAIT: begin
        wait_cnt_n = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          din_n   = mem_data;
          ready_n = 1'b1;
          state_n = ACK;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_read_mux.sv
// tb/tb_cpu_read_mux.sv - directed table-driven bench for cpu_read_mux
module tb_cpu_read_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr1 = 16'h0, cpu_addr3 = 16'h0;
  logic        cpu_rd1 = 1'b0, cpu_rd3 = 1'b0;
  logic [7:0]  cpu_din1, cpu_din3;
  logic        cpu_ready1, cpu_ready3, boot_rd1, boot_rd3, mem_rd1, mem_rd3;
  logic        boot_done1, boot_done3;
  logic [15:0] mem_addr1, mem_addr3;
  logic [7:0]  boot_data1 = 8'h00, boot_data3 = 8'h00;
  logic        boot_valid1 = 1'b1, boot_valid3 = 1'b1;
  logic [7:0]  mem_data1 = 8'hEE, mem_data3 = 8'hEE, pipe3_0 = 8'hEE, pipe3_1 = 8'hEE;
  logic        boot_rd1_q = 1'b0, boot_rd3_q = 1'b0, mem_rd1_q = 1'b0, mem_rd3_q = 1'b0;
  int          ovl_idx = 0;

  int bp1 = 0, bw1 = 0, mp1 = 0, mw1 = 0, rc1 = 0;
  int bp3 = 0, bw3 = 0, mp3 = 0, mw3 = 0, rc3 = 0;
  int ovl = 0;
  logic [15:0] ma1 = 16'h0, ma3 = 16'h0;

  int tests = 0;
  int fails = 0;

  cpu_read_mux #(.ADDR_WIDTH(16), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr1), .cpu_rd(cpu_rd1),
    .cpu_din(cpu_din1), .cpu_ready(cpu_ready1), .boot_rd(boot_rd1),
    .boot_data(boot_data1), .boot_valid(boot_valid1), .mem_addr(mem_addr1),
    .mem_rd(mem_rd1), .mem_data(mem_data1), .boot_done(boot_done1)
  );

  cpu_read_mux #(.ADDR_WIDTH(16), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr3), .cpu_rd(cpu_rd3),
    .cpu_din(cpu_din3), .cpu_ready(cpu_ready3), .boot_rd(boot_rd3),
    .boot_data(boot_data3), .boot_valid(boot_valid3), .mem_addr(mem_addr3),
    .mem_rd(mem_rd3), .mem_data(mem_data3), .boot_done(boot_done3)
  );

  function automatic logic [7:0] rom_byte(input int i);
    case (i)
      0:       return 8'hC3;
      1:       return 8'h00;
      default: return 8'hFD;
    endcase
  endfunction

  function automatic logic [7:0] memval(input logic [15:0] a);
    case (a)
      16'hFD00: return 8'h31;
      16'hFD01: return 8'h21;
      16'h1234: return 8'hA5;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // Overlay models: dut1 holds three bytes, dut3 is already empty on its first strobe.
  always @(posedge clk) begin
    boot_rd1_q <= boot_rd1;
    boot_rd3_q <= boot_rd3;
    mem_rd1_q  <= mem_rd1;
    mem_rd3_q  <= mem_rd3;
    if (boot_rd1 && !boot_rd1_q) begin
      if (ovl_idx < 3) begin
        boot_data1 <= rom_byte(ovl_idx);
        ovl_idx    <= ovl_idx + 1;
      end else begin
        boot_valid1 <= 1'b0;
      end
    end
    if (boot_rd3 && !boot_rd3_q) boot_valid3 <= 1'b0;
    // RAM models: read data valid for exactly one cycle, garbage otherwise.
    mem_data1 <= mem_rd1 ? memval(mem_addr1) : 8'hEE;
    pipe3_0   <= mem_rd3 ? memval(mem_addr3) : 8'hEE;
    pipe3_1   <= pipe3_0;
    mem_data3 <= pipe3_1;
  end

  always @(posedge clk) begin
    if (boot_rd1 && !boot_rd1_q) bp1 <= bp1 + 1;
    if (boot_rd1) bw1 <= bw1 + 1;
    if (mem_rd1 && !mem_rd1_q) mp1 <= mp1 + 1;
    if (mem_rd1) begin mw1 <= mw1 + 1; ma1 <= mem_addr1; end
    if (cpu_ready1) rc1 <= rc1 + 1;
    if (boot_rd3 && !boot_rd3_q) bp3 <= bp3 + 1;
    if (boot_rd3) bw3 <= bw3 + 1;
    if (mem_rd3 && !mem_rd3_q) mp3 <= mp3 + 1;
    if (mem_rd3) begin mw3 <= mw3 + 1; ma3 <= mem_addr3; end
    if (cpu_ready3) rc3 <= rc3 + 1;
    if ((mem_rd1 && boot_rd1) || (mem_rd3 && boot_rd3)) ovl <= ovl + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic get_counts(input int sel, output int bp, output int bw, output int mp,
                            output int mw, output int rc);
    if (sel == 1) begin bp = bp1; bw = bw1; mp = mp1; mw = mw1; rc = rc1; end
    else          begin bp = bp3; bw = bw3; mp = mp3; mw = mw3; rc = rc3; end
  endtask

  // Raises cpu_rd, counts posedges from acceptance until cpu_ready is seen, then drops cpu_rd.
  task automatic do_read(input int sel, input logic [15:0] a, input bit drop,
                         output logic [7:0] d, output int lat);
    bit got = 0;
    @(negedge clk);
    if (sel == 1) begin cpu_addr1 = a; cpu_rd1 = 1'b1; end
    else          begin cpu_addr3 = a; cpu_rd3 = 1'b1; end
    lat = 0;
    d   = 8'h00;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (sel == 1 ? cpu_ready1 : cpu_ready3) begin
        d   = (sel == 1) ? cpu_din1 : cpu_din3;
        got = 1;
      end
    end
    if (!got) lat = -1;
    if (drop) begin
      if (sel == 1) cpu_rd1 = 1'b0; else cpu_rd3 = 1'b0;
    end
  endtask

  typedef struct {
    int          sel;
    logic [15:0] addr;
    logic [7:0]  data;
    int          lat;
    int          bp;
    int          mp;
    int          done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] d;
    int lat, b0, w0, m0, n0, r0, b1, w1, m1, n1, r1, ma, done;

    vecs[0] = '{1, 16'h0000, 8'hC3, 3, 1, 0, 0};
    vecs[1] = '{1, 16'h0001, 8'h00, 3, 1, 0, 0};
    vecs[2] = '{1, 16'h0002, 8'hFD, 3, 1, 0, 0};
    vecs[3] = '{1, 16'hFD00, 8'h31, 5, 1, 1, 1};
    vecs[4] = '{1, 16'hFD01, 8'h21, 3, 0, 1, 1};
    vecs[5] = '{3, 16'h0100, 8'h5B, 7, 1, 1, 1};
    vecs[6] = '{3, 16'h1234, 8'hA5, 5, 0, 1, 1};

    repeat (3) @(negedge clk);
    chk("rst_din",       int'(cpu_din1), 0);
    chk("rst_ready",     int'(cpu_ready1), 0);
    chk("rst_boot_rd",   int'(boot_rd1), 0);
    chk("rst_mem_rd",    int'(mem_rd1), 0);
    chk("rst_boot_done", int'(boot_done1), 0);
    chk("rst_mem_addr",  int'(mem_addr1), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      get_counts(vecs[i].sel, b0, w0, m0, n0, r0);
      do_read(vecs[i].sel, vecs[i].addr, 1'b1, d, lat);
      @(negedge clk);
      get_counts(vecs[i].sel, b1, w1, m1, n1, r1);
      ma   = (vecs[i].sel == 1) ? int'(ma1) : int'(ma3);
      done = (vecs[i].sel == 1) ? int'(boot_done1) : int'(boot_done3);
      chk($sformatf("v%0d_data", i),       int'(d), int'(vecs[i].data));
      chk($sformatf("v%0d_latency", i),    lat, vecs[i].lat);
      chk($sformatf("v%0d_boot_pulses", i), b1 - b0, vecs[i].bp);
      chk($sformatf("v%0d_boot_width", i), w1 - w0, vecs[i].bp);
      chk($sformatf("v%0d_mem_pulses", i), m1 - m0, vecs[i].mp);
      chk($sformatf("v%0d_mem_width", i),  n1 - n0, vecs[i].mp);
      chk($sformatf("v%0d_ready_count", i), r1 - r0, 1);
      chk($sformatf("v%0d_boot_done", i),  done, vecs[i].done);
      if (vecs[i].mp > 0) chk($sformatf("v%0d_mem_addr", i), ma, int'(vecs[i].addr));
    end

    // Held cpu_rd must not retrigger; a one-cycle drop re-arms.
    do_read(1, 16'hFD02, 1'b0, d, lat);
    chk("hold_first_data", int'(d), 8'hA5);
    chk("hold_first_lat",  lat, 3);
    @(posedge clk);
    @(negedge clk);
    get_counts(1, b0, w0, m0, n0, r0);
    repeat (20) @(negedge clk);
    get_counts(1, b1, w1, m1, n1, r1);
    chk("hold_no_ready", r1 - r0, 0);
    chk("hold_no_mem",   m1 - m0, 0);
    chk("hold_no_boot",  b1 - b0, 0);
    cpu_rd1 = 1'b0;
    do_read(1, 16'hFD02, 1'b1, d, lat);
    chk("rearm_data", int'(d), 8'hA5);
    chk("rearm_lat",  lat, 3);
    @(negedge clk);
    get_counts(1, b1, w1, m1, n1, r1);
    chk("rearm_mem_pulses", m1 - m0, 1);

    // Reset arriving in MEM_WAIT abandons the read with no ready pulse.
    @(negedge clk);
    cpu_addr1 = 16'hFD03;
    cpu_rd1   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    get_counts(1, b0, w0, m0, n0, r0);
    reset_n = 1'b0;
    cpu_rd1 = 1'b0;
    #1;
    chk("arst_din",       int'(cpu_din1), 0);
    chk("arst_ready",     int'(cpu_ready1), 0);
    chk("arst_mem_rd",    int'(mem_rd1), 0);
    chk("arst_boot_done", int'(boot_done1), 0);
    chk("arst_mem_addr",  int'(mem_addr1), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    get_counts(1, b1, w1, m1, n1, r1);
    chk("arst_no_ready", r1 - r0, 0);
    chk("arst_no_boot",  b1 - b0, 0);
    chk("no_strobe_overlap", ovl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
